stream_lfsr_checker: RTL and testbench

Sink-side endpoint for the valid/data/stall stream protocol used by the CDC stream primitives. Consumes a stream under a programmable stall pattern, compares every accepted beat against a locally generated LFSR sequence, and reports beat count, error count, first-error details and idle timeout. It is the receiving counterpart of an LFSR stream source and sits on the destination side of a stream under test in benches and built-in self-test paths.

---
 rtl/stream_chk_pkg.sv | 18 +
 rtl/lfsr_gen.sv | 27 ++
 rtl/stream_lfsr_checker.sv | 162 ++++++++++++++++
 tb/tb_stream_lfsr_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_chk_pkg.sv
// Shared definitions for the LFSR stream checker and its matching source:
// checker states, default tap mask and the Galois LFSR step.
package stream_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_TAPS8 = 8'hB8;

    // Operates on a zero-extended value so one function serves every WIDTH up to 64.
    function automatic logic [63:0] lfsrNext(input logic [63:0] value, input logic [63:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 64'd0);
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Galois LFSR sequence generator, shared by the stream source and checker.
// load restarts the sequence at SEED and takes priority over advance.
module lfsr_gen
    import stream_chk_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS8)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] value_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_o <= SEED;
        end else if (load_i) begin
            value_o <= SEED;
        end else if (advance_i) begin
            value_o <= WIDTH'(lfsrNext(64'(value_o), 64'(TAPS)));
        end
    end

endmodule

// File: rtl/stream_lfsr_checker.sv
// Sink endpoint for the valid/data/stall stream: consumes beats under a rotating
// stall pattern, checks them against a local LFSR and reports run statistics.
module stream_lfsr_checker
    import stream_chk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               COUNT_W = 16,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEFAULT_TAPS8),
    parameter int               TIMEOUT = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] len_i,
    input  logic [7:0]         stallPat_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output logic [COUNT_W-1:0] beats_o,
    output logic [COUNT_W-1:0] errors_o,
    output logic [COUNT_W-1:0] firstErrIdx_o,
    output logic [WIDTH-1:0]   firstErrData_o,
    output state_t             dbgState_o
);

    state_t             state;
    state_t             stateNext;
    logic [COUNT_W-1:0] lenReg;
    logic [7:0]         patReg;
    logic [COUNT_W-1:0] beats;
    logic [COUNT_W-1:0] errors;
    logic [COUNT_W-1:0] firstErrIdx;
    logic [WIDTH-1:0]   firstErrData;
    logic               passReg;
    logic               timeoutReg;
    logic [31:0]        idleCnt;
    logic [WIDTH-1:0]   lfsrVal;

    logic               startRun;
    logic               xfer;
    logic               mismatch;
    logic [COUNT_W-1:0] beatsInc;
    logic [COUNT_W-1:0] errorsNext;
    logic               lastBeat;
    logic               idleExpire;

    // Stream handshake: a beat moves on a clock edge exactly when valid_i is high
    // and stall_o is low. stall_o depends only on registered state, never on valid_i.
    assign stall_o  = (state != RUN) || patReg[0];
    assign xfer     = valid_i && !stall_o;
    assign startRun = (state != RUN) && start_i;
    assign mismatch = (data_i != lfsrVal);
    assign beatsInc = beats + 1'b1;
    assign lastBeat = xfer && (beatsInc == lenReg);

    always_comb begin
        errorsNext = errors;
        if (xfer && mismatch && (errors != '1)) begin
            errorsNext = errors + 1'b1;
        end
    end

    // A completing transfer beats a timeout landing on the same edge.
    assign idleExpire = (TIMEOUT > 0) && (state == RUN) && !xfer
                        && ((idleCnt + 32'd1) == 32'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    stateNext = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastBeat || idleExpire) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lenReg       <= '0;
            patReg       <= '0;
            beats        <= '0;
            errors       <= '0;
            firstErrIdx  <= '0;
            firstErrData <= '0;
            passReg      <= 1'b0;
            timeoutReg   <= 1'b0;
            idleCnt      <= '0;
        end else if (startRun) begin
            lenReg       <= len_i;
            patReg       <= stallPat_i;
            beats        <= '0;
            errors       <= '0;
            firstErrIdx  <= '0;
            firstErrData <= '0;
            passReg      <= (len_i == '0);
            timeoutReg   <= 1'b0;
            idleCnt      <= '0;
        end else if (state == RUN) begin
            patReg <= {patReg[0], patReg[7:1]};
            if (xfer) begin
                beats   <= beatsInc;
                errors  <= errorsNext;
                idleCnt <= '0;
                if (mismatch && (errors == '0)) begin
                    firstErrIdx  <= beats;
                    firstErrData <= data_i;
                end
            end else begin
                idleCnt <= idleCnt + 32'd1;
            end
            if (lastBeat) begin
                passReg <= (errorsNext == '0);
            end else if (idleExpire) begin
                passReg    <= 1'b0;
                timeoutReg <= 1'b1;
            end
        end
    end

    lfsr_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) uLfsr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (startRun),
        .advance_i (xfer),
        .value_o   (lfsrVal)
    );

    assign busy_o         = (state == RUN);
    assign done_o         = (state == DONE);
    assign pass_o         = passReg;
    assign timeout_o      = timeoutReg;
    assign beats_o        = beats;
    assign errors_o       = errors;
    assign firstErrIdx_o  = firstErrIdx;
    assign firstErrData_o = firstErrData;
    assign dbgState_o     = state;

endmodule

// File: tb/tb_stream_lfsr_checker.sv
// Randomised self-checking bench for stream_lfsr_checker against a cycle-level
// behavioural model of the stall pattern, LFSR sequence, error capture and timeout.
module tb_stream_lfsr_checker;
  import stream_chk_pkg::*;

  localparam int WIDTH = 8;
  localparam int COUNT_W = 16;
  localparam int TIMEOUT = 16;
  localparam logic [7:0] SEED = 8'h01;
  localparam logic [7:0] TAPS = 8'hB8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic [COUNT_W-1:0] len_i = '0;
  logic [7:0] stallPat_i = '0;
  logic valid_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic stall_o, busy_o, done_o, pass_o, timeout_o;
  logic [COUNT_W-1:0] beats_o, errors_o, firstErrIdx_o;
  logic [WIDTH-1:0] firstErrData_o;
  state_t dbgState_o;

  int errors_n = 0;
  int checks_n = 0;

  // scoreboard and model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] lfsr_seq[$];
  logic [WIDTH-1:0] corrupt[$];
  int obs_stall[$];
  int m_beats, m_errs, m_first_idx;
  logic [WIDTH-1:0] m_first_data;
  bit m_timeout;
  int stall_bad, busy_bad;

  stream_lfsr_checker #(
    .WIDTH(WIDTH), .COUNT_W(COUNT_W), .SEED(SEED), .TAPS(TAPS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .stallPat_i(stallPat_i), .valid_i(valid_i), .data_i(data_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .beats_o(beats_o), .errors_o(errors_o),
    .firstErrIdx_o(firstErrIdx_o), .firstErrData_o(firstErrData_o),
    .dbgState_o(dbgState_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  // Galois LFSR step taken directly from the sequence definition.
  function automatic logic [7:0] ref_next(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 8'h00);
  endfunction

  task automatic prepare(input int len, input int corrupt_pct);
    logic [7:0] x;
    x = SEED;
    lfsr_seq = {};
    corrupt = {};
    for (int i = 0; i < len; i++) begin
      lfsr_seq.push_back(x);
      if ($urandom_range(1, 100) <= corrupt_pct) corrupt.push_back(8'($urandom_range(1, 255)));
      else corrupt.push_back(8'h00);
      x = ref_next(x);
    end
  endtask

  // Drives one run and advances the model; DUT stall/busy deviations are tallied.
  task automatic drive_run(input int len, input logic [7:0] pat, input int n_send,
                           input int valid_pct, input bit noise_start);
    int idx, idle, k;
    bit running, v, s;
    logic [7:0] d_sent, e;
    idx = 0; idle = 0; k = 0;
    m_errs = 0; m_first_idx = 0; m_first_data = '0; m_timeout = 0;
    stall_bad = 0; busy_bad = 0;
    obs_stall = {};
    exp_q = {};
    foreach (lfsr_seq[i]) exp_q.push_back(lfsr_seq[i]);
    d_sent = '0;
    @(negedge clk);
    start_i = 1'b1; len_i = COUNT_W'(len); stallPat_i = pat; valid_i = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b0;
    running = (len != 0);
    while (running && k < 2000) begin
      @(negedge clk);
      s = pat[k % 8];
      obs_stall.push_back(int'(stall_o));
      if (stall_o !== s) stall_bad++;
      if (busy_o !== 1'b1) busy_bad++;
      v = (idx < n_send) && ($urandom_range(1, 100) <= valid_pct);
      d_sent = v ? (lfsr_seq[idx] ^ corrupt[idx]) : 8'($urandom);
      valid_i = v;
      data_i = d_sent;
      if (noise_start) begin
        start_i = 1'($urandom_range(0, 1));
        len_i = COUNT_W'($urandom);
        stallPat_i = 8'($urandom);
      end
      @(posedge clk);
      if (v && !s) begin
        e = exp_q.pop_front();
        if (d_sent !== e) begin
          if (m_errs == 0) begin
            m_first_idx = idx;
            m_first_data = d_sent;
          end
          m_errs++;
        end
        idx++;
        idle = 0;
        if (idx == len) running = 0;
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          running = 0;
          m_timeout = 1;
        end
      end
      k++;
    end
    if (running) busy_bad++;
    #1 valid_i = 1'b0; start_i = 1'b0;
    m_beats = idx;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks_n++; if (stall_o !== 1'b1) begin errors_n++; $display("FAIL reset_stall: got %b want 1", stall_o); end
    checks_n++; if ({busy_o, done_o, pass_o, timeout_o} !== 4'b0000) begin errors_n++;
      $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, pass_o, timeout_o}); end
    checks_n++; if ({beats_o, errors_o, firstErrIdx_o, firstErrData_o} !== '0) begin errors_n++;
      $display("FAIL reset_counters: got %h/%h/%h/%h want 0", beats_o, errors_o, firstErrIdx_o, firstErrData_o); end
    checks_n++; if (dbgState_o !== IDLE) begin errors_n++; $display("FAIL reset_state: got %0d want IDLE", dbgState_o); end
  endtask

  task automatic test_basic();
    prepare(4, 0);
    drive_run(4, 8'h00, 4, 100, 0);
    @(negedge clk);
    checks_n++; if (stall_bad !== 0 || busy_bad !== 0 || obs_stall.size() !== 4) begin errors_n++;
      $display("FAIL basic_timing: stall_bad=%0d busy_bad=%0d cycles=%0d want 0/0/4", stall_bad, busy_bad, obs_stall.size()); end
    checks_n++; if ({done_o, pass_o, timeout_o, stall_o} !== 4'b1101) begin errors_n++;
      $display("FAIL basic_flags: got %b want 1101", {done_o, pass_o, timeout_o, stall_o}); end
    checks_n++; if (beats_o !== 16'd4 || errors_o !== 16'd0) begin errors_n++;
      $display("FAIL basic_counts: got beats=%0d errors=%0d want 4/0", beats_o, errors_o); end
    repeat (3) @(negedge clk);
    checks_n++; if ({done_o, pass_o, beats_o} !== {2'b11, 16'd4}) begin errors_n++;
      $display("FAIL basic_hold: got done=%b pass=%b beats=%0d want 1/1/4", done_o, pass_o, beats_o); end
  endtask

  task automatic test_stall_pattern();
    int exp_pat[10] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int bad;
    prepare(8, 0);
    drive_run(8, 8'b0000_0101, 8, 100, 0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) if (i >= obs_stall.size() || obs_stall[i] != exp_pat[i]) bad++;
    checks_n++; if (bad !== 0) begin errors_n++; $display("FAIL pattern_seq: got %0d bad positions want 0", bad); end
    checks_n++; if (stall_bad !== 0 || busy_bad !== 0) begin errors_n++;
      $display("FAIL pattern_timing: stall_bad=%0d busy_bad=%0d want 0", stall_bad, busy_bad); end
    checks_n++; if ({done_o, pass_o} !== 2'b11 || beats_o !== 16'd8) begin errors_n++;
      $display("FAIL pattern_result: got done=%b pass=%b beats=%0d want 1/1/8", done_o, pass_o, beats_o); end
  endtask

  task automatic test_error();
    prepare(4, 0);
    corrupt[2] = 8'h01;
    drive_run(4, 8'h00, 4, 100, 0);
    @(negedge clk);
    checks_n++; if (errors_o !== 16'd1) begin errors_n++; $display("FAIL err_count: got %0d want 1", errors_o); end
    checks_n++; if (firstErrIdx_o !== 16'd2 || firstErrData_o !== 8'h5D) begin errors_n++;
      $display("FAIL err_capture: got idx=%0d data=%h want 2/5d", firstErrIdx_o, firstErrData_o); end
    checks_n++; if ({done_o, pass_o, timeout_o} !== 3'b100 || beats_o !== 16'd4) begin errors_n++;
      $display("FAIL err_flags: got %b beats=%0d want 100/4", {done_o, pass_o, timeout_o}, beats_o); end
  endtask

  task automatic test_len_zero();
    prepare(0, 0);
    drive_run(0, 8'h00, 0, 100, 0);
    @(negedge clk);
    checks_n++; if ({busy_o, done_o, pass_o, stall_o} !== 4'b0111 || beats_o !== 16'd0) begin errors_n++;
      $display("FAIL len0: got busy/done/pass/stall=%b beats=%0d want 0111/0", {busy_o, done_o, pass_o, stall_o}, beats_o); end
  endtask

  task automatic test_timeout();
    prepare(4, 0);
    drive_run(4, 8'h00, 2, 100, 0);
    @(negedge clk);
    checks_n++; if (busy_bad !== 0 || obs_stall.size() !== 2 + TIMEOUT) begin errors_n++;
      $display("FAIL to_timing: busy_bad=%0d cycles=%0d want 0/%0d", busy_bad, obs_stall.size(), 2 + TIMEOUT); end
    checks_n++; if ({done_o, timeout_o, pass_o} !== 3'b110 || beats_o !== 16'd2) begin errors_n++;
      $display("FAIL to_result: got done/to/pass=%b beats=%0d want 110/2", {done_o, timeout_o, pass_o}, beats_o); end
  endtask

  task automatic test_reset_midrun();
    prepare(8, 0);
    @(negedge clk);
    start_i = 1'b1; len_i = 16'd8; stallPat_i = 8'h00;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1; data_i = lfsr_seq[i];
      @(posedge clk);
    end
    @(negedge clk);
    rst_ni = 1'b0; start_i = 1'b1; len_i = 16'd5; valid_i = 1'b1;
    @(posedge clk);
    #1 rst_ni = 1'b1; start_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    checks_n++; if ({busy_o, done_o, pass_o, timeout_o, stall_o} !== 5'b00001) begin errors_n++;
      $display("FAIL rst_mid_flags: got %b want 00001", {busy_o, done_o, pass_o, timeout_o, stall_o}); end
    checks_n++; if ({beats_o, errors_o, firstErrIdx_o, firstErrData_o} !== '0) begin errors_n++;
      $display("FAIL rst_mid_counters: got beats=%0d errors=%0d", beats_o, errors_o); end
    prepare(6, 0);
    drive_run(6, 8'h00, 6, 100, 0);
    @(negedge clk);
    checks_n++; if ({done_o, pass_o} !== 2'b11 || beats_o !== 16'd6 || busy_bad !== 0) begin errors_n++;
      $display("FAIL rst_mid_rerun: got done=%b pass=%b beats=%0d want 1/1/6", done_o, pass_o, beats_o); end
  endtask

  task automatic test_random();
    int len, pct;
    logic [7:0] pat;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 24);
      pat = (it == 7) ? 8'hFF : 8'($urandom);
      pct = $urandom_range(50, 100);
      prepare(len, 20);
      drive_run(len, pat, len, pct, 1);
      @(negedge clk);
      checks_n++; if (stall_bad !== 0 || busy_bad !== 0) begin errors_n++;
        $display("FAIL rand%0d_timing: stall_bad=%0d busy_bad=%0d", it, stall_bad, busy_bad); end
      checks_n++; if ({done_o, timeout_o, pass_o} !== {1'b1, m_timeout, (m_errs == 0) && !m_timeout}) begin errors_n++;
        $display("FAIL rand%0d_flags: got done/to/pass=%b want 1/%b/%b", it, {done_o, timeout_o, pass_o}, m_timeout, (m_errs == 0) && !m_timeout); end
      checks_n++; if (beats_o !== COUNT_W'(m_beats) || errors_o !== COUNT_W'(m_errs)) begin errors_n++;
        $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", it, beats_o, errors_o, m_beats, m_errs); end
      checks_n++; if (firstErrIdx_o !== COUNT_W'(m_first_idx) || firstErrData_o !== m_first_data) begin errors_n++;
        $display("FAIL rand%0d_first: got %0d/%h want %0d/%h", it, firstErrIdx_o, firstErrData_o, m_first_idx, m_first_data); end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_basic();
    test_stall_pattern();
    test_error();
    test_len_zero();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end

endmodule
